// File: rtl/vx_mul_pipe.sv
// Elastic multi-lane RISC-V integer multiplier (MUL/MULH/MULHSU/MULHU).
// Valid/ready pipeline with bubble collapse and per-request tag pass-through.
module vx_mul_pipe #(
    parameter int LANES     = 1,
    parameter int WIDTH     = 32,
    parameter int TAG_WIDTH = 1,
    parameter int LATENCY   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_in,
    output logic                   ready_in,
    input  logic [1:0]             op_in,
    input  logic [LANES*WIDTH-1:0] dataa_in,
    input  logic [LANES*WIDTH-1:0] datab_in,
    input  logic [TAG_WIDTH-1:0]   tag_in,
    output logic                   valid_out,
    input  logic                   ready_out,
    output logic [LANES*WIDTH-1:0] result_out,
    output logic [TAG_WIDTH-1:0]   tag_out
);

    localparam int DW = LANES * WIDTH;

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("vx_mul_pipe: LATENCY must be in 1..4");
    end

    logic           sign_a;
    logic           sign_b;
    logic [DW-1:0]  prod_res;

    assign sign_a = (op_in == 2'd1) || (op_in == 2'd2);
    assign sign_b = (op_in == 2'd1);

    // Low 2*WIDTH bits of the (WIDTH+1)-bit signed product are all any op needs.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic [2*WIDTH-1:0] a_big;
        logic [2*WIDTH-1:0] b_big;
        logic [2*WIDTH-1:0] prod;

        assign a     = dataa_in[l*WIDTH +: WIDTH];
        assign b     = datab_in[l*WIDTH +: WIDTH];
        assign a_big = {{WIDTH{sign_a & a[WIDTH-1]}}, a};
        assign b_big = {{WIDTH{sign_b & b[WIDTH-1]}}, b};
        assign prod  = a_big * b_big;

        assign prod_res[l*WIDTH +: WIDTH] =
            (op_in == 2'd0) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end

    logic [LATENCY-1:0]   v;
    logic [LATENCY-1:0]   adv;
    logic [LATENCY-1:0]   load;
    logic [DW-1:0]        res_q [LATENCY];
    logic [TAG_WIDTH-1:0] tag_q [LATENCY];

    // A stage can release its entry if any downstream stage is empty or the sink is ready.
    always_comb begin
        adv = '0;
        for (int i = 0; i < LATENCY; i++) begin
            adv[i] = ready_out;
            for (int j = i + 1; j < LATENCY; j++) begin
                if (!v[j]) adv[i] = 1'b1;
            end
        end
    end

    assign load     = ~v | adv;
    assign ready_in = !reset && load[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            v <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                res_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            if (load[0]) begin
                v[0] <= valid_in;
                if (valid_in) begin
                    res_q[0] <= prod_res;
                    tag_q[0] <= tag_in;
                end
            end
            for (int i = 1; i < LATENCY; i++) begin
                if (load[i]) begin
                    v[i] <= v[i-1];
                    if (v[i-1]) begin
                        res_q[i] <= res_q[i-1];
                        tag_q[i] <= tag_q[i-1];
                    end
                end
            end
        end
    end

    assign valid_out  = v[LATENCY-1];
    assign result_out = res_q[LATENCY-1];
    assign tag_out    = tag_q[LATENCY-1];

endmodule

// File: tb/tb_vx_mul_pipe.sv
// Directed bench for vx_mul_pipe: a 4-lane LATENCY=3 instance
// and a 1-lane LATENCY=4 instance for bubble collapse.
module tb_vx_mul_pipe;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    logic         a_vin, a_rdy, a_vout, a_rout;
    logic [1:0]   a_op;
    logic [127:0] a_da, a_db, a_res;
    logic [7:0]   a_tag, a_tago;

    logic         b_vin, b_rdy, b_vout, b_rout;
    logic [1:0]   b_op;
    logic [31:0]  b_da, b_db, b_res;
    logic [7:0]   b_tag, b_tago;

    vx_mul_pipe #(
        .LANES(4), .WIDTH(32), .TAG_WIDTH(8), .LATENCY(3)
    ) u_a (
        .clk(clk), .reset(reset),
        .valid_in(a_vin), .ready_in(a_rdy), .op_in(a_op),
        .dataa_in(a_da), .datab_in(a_db), .tag_in(a_tag),
        .valid_out(a_vout), .ready_out(a_rout),
        .result_out(a_res), .tag_out(a_tago)
    );

    vx_mul_pipe #(
        .LANES(1), .WIDTH(32), .TAG_WIDTH(8), .LATENCY(4)
    ) u_b (
        .clk(clk), .reset(reset),
        .valid_in(b_vin), .ready_in(b_rdy), .op_in(b_op),
        .dataa_in(b_da), .datab_in(b_db), .tag_in(b_tag),
        .valid_out(b_vout), .ready_out(b_rout),
        .result_out(b_res), .tag_out(b_tago)
    );

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (a_vout !== 1'b0) begin bad++; $display("FAIL rst_vout: got %b want 0", a_vout); end
        total++; if (a_rdy !== 1'b0) begin bad++; $display("FAIL rst_rdy: got %b want 0", a_rdy); end
        total++; if (a_res !== 128'h0) begin bad++; $display("FAIL rst_res: got %h want 0", a_res); end
        total++; if (a_tago !== 8'h0) begin bad++; $display("FAIL rst_tag: got %h want 0", a_tago); end
        total++; if (b_vout !== 1'b0 || b_rdy !== 1'b0) begin
            bad++; $display("FAIL rst_b: got vout=%b rdy=%b want 0 0", b_vout, b_rdy);
        end
        reset = 1'b0;
        #1;
        total++; if (a_rdy !== 1'b1 || b_rdy !== 1'b1) begin
            bad++; $display("FAIL rst_release_rdy: got %b %b want 1 1", a_rdy, b_rdy);
        end
    endtask

    task automatic test_modes();
        logic [1:0]  ops [5] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
        logic [31:0] va  [5] = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] vb  [5] = '{32'h2, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] ve  [5] = '{32'hFFFFFFFE, 32'h40000000, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE};
        int lat;
        a_rout = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            a_vin = 1'b1; a_op = ops[k];
            a_da = {96'h0, va[k]}; a_db = {96'h0, vb[k]}; a_tag = 8'(k);
            @(negedge clk);
            a_vin = 1'b0;
            lat = 1;
            while (!a_vout && lat < 10) begin @(negedge clk); lat++; end
            total++; if (lat !== 3) begin bad++; $display("FAIL mode%0d_latency: got %0d want 3", k, lat); end
            total++; if (a_res !== {96'h0, ve[k]}) begin
                bad++; $display("FAIL mode%0d_result: got %h want %h", k, a_res, ve[k]);
            end
            total++; if (a_tago !== 8'(k)) begin bad++; $display("FAIL mode%0d_tag: got %h want %h", k, a_tago, k); end
        end
    endtask

    task automatic test_lanes();
        logic [127:0] exp = {32'h0, 32'hFFFFFFFE, 32'hFFFFFFFA, 32'h3};
        int lat;
        a_rout = 1'b1;
        @(negedge clk);
        a_vin = 1'b1; a_op = 2'd0; a_tag = 8'h55;
        a_da = {32'h0, 32'h7FFFFFFF, 32'hFFFFFFFE, 32'h1};
        a_db = {32'hFFFFFFFF, 32'h2, 32'h3, 32'h3};
        @(negedge clk);
        a_vin = 1'b0;
        lat = 1;
        while (!a_vout && lat < 10) begin @(negedge clk); lat++; end
        total++; if (a_vout !== 1'b1) begin bad++; $display("FAIL lanes_valid: got %b want 1", a_vout); end
        for (int l = 0; l < 4; l++) begin
            total++;
            if (a_res[l*32 +: 32] !== exp[l*32 +: 32]) begin
                bad++; $display("FAIL lane%0d_result: got %h want %h", l, a_res[l*32 +: 32], exp[l*32 +: 32]);
            end
        end
    endtask

    task automatic test_streaming();
        int sent = 0;
        int rx = 0;
        int first = -1;
        int drop = 0;
        a_rout = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            a_vin = (sent < 16); a_op = 2'd0; a_tag = 8'(sent);
            a_da = 128'(sent); a_db = 128'(3);
            #1;
            if (a_vout && a_rout) begin
                if (first < 0) first = c;
                total++; if (a_tago !== 8'(rx)) begin bad++; $display("FAIL stream_tag: got %0d want %0d", a_tago, rx); end
                total++; if (a_res !== 128'(rx * 3)) begin bad++; $display("FAIL stream_res: got %h want %h", a_res, rx * 3); end
                rx++;
            end
            if (sent < 16 && !a_rdy) drop++;
            if (a_vin && a_rdy) sent++;
        end
        a_vin = 1'b0;
        total++; if (first !== 3) begin bad++; $display("FAIL stream_first: got %0d want 3", first); end
        total++; if (rx !== 16) begin bad++; $display("FAIL stream_count: got %0d want 16", rx); end
        total++; if (drop !== 0) begin bad++; $display("FAIL stream_ready_drop: got %0d want 0", drop); end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int rx = 0;
        int stall_acc = 0;
        logic hold_prev = 1'b0;
        logic [127:0] held_res = '0;
        logic [7:0] held_tag = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            a_rout = (c >= 6);
            a_vin = (sent < 10); a_op = 2'd0; a_tag = 8'(sent);
            a_da = 128'(sent + 1); a_db = 128'(5);
            #1;
            if (hold_prev) begin
                total++;
                if (a_res !== held_res || a_tago !== held_tag) begin
                    bad++; $display("FAIL bp_stable: got %h/%h want %h/%h", a_res, a_tago, held_res, held_tag);
                end
            end
            hold_prev = a_vout && !a_rout;
            held_res = a_res; held_tag = a_tago;
            if (c == 5) begin
                total++; if (a_rdy !== 1'b0) begin bad++; $display("FAIL bp_full_rdy: got %b want 0", a_rdy); end
            end
            if (a_vout && a_rout) begin
                total++; if (a_tago !== 8'(rx)) begin bad++; $display("FAIL bp_tag: got %0d want %0d", a_tago, rx); end
                total++; if (a_res !== 128'((rx + 1) * 5)) begin bad++; $display("FAIL bp_res: got %h want %h", a_res, (rx + 1) * 5); end
                rx++;
            end
            if (a_vin && a_rdy) begin
                sent++;
                if (c < 6) stall_acc++;
            end
        end
        a_vin = 1'b0;
        total++; if (stall_acc !== 3) begin bad++; $display("FAIL bp_accepts: got %0d want 3", stall_acc); end
        total++; if (rx !== 10) begin bad++; $display("FAIL bp_count: got %0d want 10", rx); end
    endtask

    task automatic test_bubble();
        int sent = 0;
        int rx = 0;
        b_rout = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            b_vin = (c == 0 || c == 3 || c == 5); b_op = 2'd0; b_tag = 8'(sent);
            b_da = 32'(sent + 1); b_db = 32'd2;
            #1;
            if (b_vin) begin
                total++; if (b_rdy !== 1'b1) begin bad++; $display("FAIL bubble_accept%0d: got %b want 1", c, b_rdy); end
            end
            if (b_vin && b_rdy) sent++;
        end
        b_vin = 1'b0;
        total++; if (b_vout !== 1'b1 || b_tago !== 8'h0) begin
            bad++; $display("FAIL bubble_head: got v=%b tag=%0d want 1 0", b_vout, b_tago);
        end
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            b_rout = 1'b1;
            #1;
            if (b_vout) begin
                total++; if (b_tago !== 8'(rx)) begin bad++; $display("FAIL bubble_tag: got %0d want %0d", b_tago, rx); end
                total++; if (b_res !== 32'((rx + 1) * 2)) begin bad++; $display("FAIL bubble_res: got %h want %h", b_res, (rx + 1) * 2); end
                rx++;
            end
        end
        total++; if (rx !== 3) begin bad++; $display("FAIL bubble_count: got %0d want 3", rx); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        a_rout = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            a_vin = 1'b1; a_tag = 8'(8'hA0 + c); a_da = 128'(7); a_db = 128'(7);
            #1;
            total++; if (a_rdy !== 1'b1) begin bad++; $display("FAIL rmid_accept%0d: got %b want 1", c, a_rdy); end
        end
        @(negedge clk);
        a_vin = 1'b0; reset = 1'b1;
        #1;
        total++; if (a_rdy !== 1'b0) begin bad++; $display("FAIL rmid_rdy_in_reset: got %b want 0", a_rdy); end
        @(negedge clk);
        total++; if (a_vout !== 1'b0) begin bad++; $display("FAIL rmid_vout: got %b want 0", a_vout); end
        total++; if (a_rdy !== 1'b0) begin bad++; $display("FAIL rmid_rdy: got %b want 0", a_rdy); end
        reset = 1'b0; a_rout = 1'b1;
        #1;
        total++; if (a_rdy !== 1'b1) begin bad++; $display("FAIL rmid_rdy_after: got %b want 1", a_rdy); end
        repeat (10) begin
            @(negedge clk);
            if (a_vout) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rmid_ghost: got %0d outputs want 0", seen); end
    endtask

    initial begin
        reset = 1'b1;
        a_vin = 1'b0; a_rout = 1'b0; a_op = 2'd0; a_da = '0; a_db = '0; a_tag = '0;
        b_vin = 1'b0; b_rout = 1'b0; b_op = 2'd0; b_da = '0; b_db = '0; b_tag = '0;
        test_reset();
        test_modes();
        test_lanes();
        repeat (4) @(negedge clk);
        test_streaming();
        test_backpressure();
        test_bubble();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
